irq_controller: RTL and testbench
=================================

# irq_controller

Prioritized interrupt controller sitting directly upstream of the multicycle MIPS `Controller`. It collects `NUM_IRQ` maskable request lines and one non-maskable edge source, resolves priority, and drives the controller's `INT`/`NMI`/`INTD` inputs. It consumes the controller's acceptance handshake (`isInterrupted`, `INA`) and its return-from-interrupt pulse. On each acceptance it produces the handler vector and tracks in-service state.

## Interface
- `NUM_IRQ`, 4, number of maskable sources (1..8); index 0 has the highest priority
- `VEC_BASE`, 32'h0000_0100, maskable vector base; vector = `VEC_BASE + (id << 4)`
- `NMI_VEC`, 32'h0000_0080, NMI handler address
- `SPUR_VEC`, 32'h0000_01F0, vector for a spurious maskable acceptance
- Clock and reset: one clock; reset is synchronous and active-high.
- `Clk` in 1: clock; all state changes on the rising edge
- `Reset` in 1: synchronous reset, active-high
- `irq` in NUM_IRQ: level-sensitive maskable requests
- `nmi_in` in 1: NMI source, rising-edge sensitive
- `mask_we` in 1: load the mask register
- `mask_wdata` in NUM_IRQ: new mask; 1 = enabled
- `isInterrupted` in 1: acceptance pulse from `Controller` (preFetch)
- `INA` in 1: qualifies the acceptance; 1 = maskable, 0 = NMI
- `eret` in 1: one-cycle return-from-interrupt pulse
- `INT` out 1: maskable request to `Controller`
- `NMI` out 1: NMI request to `Controller`
- `INTD` out 1: interrupt-disable to `Controller`
- `irq_id` out 3: id of the last accepted maskable source
- `vector` out 32: handler address of the last acceptance
- `spurious` out 1: last maskable acceptance found nothing pending
- `in_service` out NUM_IRQ: in-service bits
- `nmi_active` out 1: NMI handler running

## Operation
- **Maskable pending:** `req = irq & mask`.
  - `sel` = lowest index set in `req`.
  - `INT` register loads `(req != 0) & !INTD_next`.
- **NMI detection:**
  - `nmi_q` samples `nmi_in` every cycle.
  - `nmi_in & !nmi_q` sets `nmi_pend`.
  - The `NMI` output equals `nmi_pend`.
  - An NMI edge while `nmi_pend` is already set is merged into the pending request (not counted twice).
- **INTD:** `nmi_active | (in_service != 0)`.
- **Maskable acceptance** (`isInterrupted & INA`):
  - If `req != 0`: set `in_service[sel]`, `irq_id <= sel`, `vector <= VEC_BASE + (sel<<4)`, `spurious <= 0`.
  - Else: `spurious <= 1`, `vector <= SPUR_VEC`, `irq_id` unchanged, `in_service` unchanged.
- **NMI acceptance** (`isInterrupted & !INA`):
  - Clear `nmi_pend`, set `nmi_active`, `vector <= NMI_VEC`.
  - If `nmi_pend` was already 0, the acceptance has no state effect except `vector`.
- **eret:**
  - If `nmi_active` is set, clear it.
  - Else clear the lowest-index set bit of `in_service`.
  - With nothing active, `eret` is ignored.
- **Simultaneous events:**
  - `eret` and an acceptance in the same cycle: the `eret` clear applies first, then the acceptance set.
  - `mask_we` and an acceptance in the same cycle: the acceptance uses the old mask; the new mask is visible next cycle.
  - NMI edge and NMI acceptance in the same cycle: `nmi_pend` stays 1 (the new edge survives).
- **Reset:**
  - `mask = 0`; `nmi_pend`, `nmi_active`, `in_service`, `INT`, `spurious` = 0.
  - `irq_id = 0`, `vector = VEC_BASE`.
  - `nmi_q <= nmi_in`, so an `nmi_in` held high through reset does not produce an NMI.
  - Reset mid-service discards all service state.

## Timing
- `irq` → `INT`: 1 cycle (registered).
- `nmi_in` rise → `NMI`: 1 cycle.
- Acceptance edge → `vector`, `irq_id`, `in_service`, `nmi_active`, `INTD` valid on the next cycle.
- `INTD` and `NMI` are decoded from registers with no combinational path from inputs.
- `INT` deasserts no later than 1 cycle after a maskable acceptance, because `INTD` rises.

## Configuration
- `IRQ_NESTING_EN`
  - **Defined:** maskable `INTD = nmi_active`. `INT` is requested only when `sel` is strictly lower-indexed than every set `in_service` bit, so higher-priority sources preempt. Multiple `in_service` bits may be set.
  - **Undefined:** no nesting; at most one `in_service` bit is set.

## Test plan
- Reset, `mask=4'b1111`, `irq=4'b0100` → `INT=1` next cycle; accept with `INA=1` → `irq_id=2`, `vector=0x120`, `in_service=4'b0100`, `INT=0`, `INTD=1`.
- `irq=4'b1010`, `mask=4'b1110` → accept gives `irq_id=1`, `vector=0x110`; `eret` → `in_service=0`, `INTD=0`.
- During service of id 2, pulse `nmi_in` → `NMI=1`; accept with `INA=0` → `vector=0x80`, `nmi_active=1`; `eret` clears only `nmi_active`, then a second `eret` clears `in_service[2]`.
- Drop `irq` to 0 in the same cycle as `isInterrupted=1, INA=1` → `spurious=1`, `vector=0x1F0`, `in_service` unchanged.
- Hold `nmi_in=1` across `Reset` → `NMI` stays 0; a subsequent fall then rise → `NMI=1`.
- With `IRQ_NESTING_EN`: id 3 in service, raise `irq[0]` → `INT=1`, accept → `in_service=4'b1001`; without the macro, `INT` stays 0.

Source files
------------

// File: rtl/irq_controller.sv
// irq_controller: prioritized maskable/NMI interrupt controller for the MIPS Controller; define IRQ_NESTING_EN for preemptive nesting
module irq_controller #(
  parameter int          NUM_IRQ  = 4,
  parameter logic [31:0] VEC_BASE = 32'h0000_0100,
  parameter logic [31:0] NMI_VEC  = 32'h0000_0080,
  parameter logic [31:0] SPUR_VEC = 32'h0000_01F0
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic               nmi_in,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               isInterrupted,
  input  logic               INA,
  input  logic               eret,
  output logic               INT,
  output logic               NMI,
  output logic               INTD,
  output logic [2:0]         irq_id,
  output logic [31:0]        vector,
  output logic               spurious,
  output logic [NUM_IRQ-1:0] in_service,
  output logic               nmi_active
);
  logic [NUM_IRQ-1:0] mask_q, mask_d, isv_q, isv_d, isv_ret, req;
  logic               nmi_q, pend_q, pend_d, act_q, act_d, int_q, int_d, spur_q, spur_d;
  logic [2:0]         id_q, id_d, sel;
  logic [31:0]        vec_q, vec_d;
  logic [3:0]         isv_low;
  logic               acc_m, acc_n, nmi_edge, req_any;

  assign req      = irq & mask_q;
  assign req_any  = |req;
  assign acc_m    = isInterrupted & INA;
  assign acc_n    = isInterrupted & ~INA;
  assign nmi_edge = nmi_in & ~nmi_q;

  // lowest-index pending request wins
  always_comb begin
    sel = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (req[i]) sel = 3'(i);
  end

  // lowest-index in-service bit after this cycle's updates; NUM_IRQ when none
  always_comb begin
    isv_low = 4'(NUM_IRQ);
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (isv_d[i]) isv_low = 4'(i);
  end

  // next state: eret clears first, then the acceptance sets
  always_comb begin
    isv_ret = (eret && !act_q) ? isv_q & ~(isv_q & (-isv_q)) : isv_q;
    mask_d  = mask_we ? mask_wdata : mask_q;
    pend_d  = nmi_edge | (pend_q & ~acc_n);
    act_d   = (acc_n & pend_q) | (act_q & ~eret);
    isv_d   = (acc_m && req_any) ? isv_ret | (NUM_IRQ'(1) << sel) : isv_ret;
    id_d    = (acc_m && req_any) ? sel : id_q;
    spur_d  = acc_m ? ~req_any : spur_q;
    vec_d   = acc_n ? NMI_VEC : acc_m ? (req_any ? VEC_BASE + (32'(sel) << 4) : SPUR_VEC) : vec_q;
`ifdef IRQ_NESTING_EN
    int_d   = req_any & ~act_d & ({1'b0, sel} < isv_low);
`else
    int_d   = req_any & ~(act_d | (isv_low != 4'(NUM_IRQ)));
`endif
  end

  // state registers; nmi_q tracks nmi_in even in reset so a held line gives no edge
  always_ff @(posedge Clk) begin
    nmi_q <= nmi_in;
    if (Reset) begin
      mask_q <= '0;
      pend_q <= 1'b0;
      act_q  <= 1'b0;
      isv_q  <= '0;
      int_q  <= 1'b0;
      spur_q <= 1'b0;
      id_q   <= '0;
      vec_q  <= VEC_BASE;
    end else begin
      mask_q <= mask_d;
      pend_q <= pend_d;
      act_q  <= act_d;
      isv_q  <= isv_d;
      int_q  <= int_d;
      spur_q <= spur_d;
      id_q   <= id_d;
      vec_q  <= vec_d;
    end
  end

  assign INT        = int_q;
  assign NMI        = pend_q;
`ifdef IRQ_NESTING_EN
  assign INTD       = act_q;
`else
  assign INTD       = act_q | (|isv_q);
`endif
  assign irq_id     = id_q;
  assign vector     = vec_q;
  assign spurious   = spur_q;
  assign in_service = isv_q;
  assign nmi_active = act_q;
endmodule

// File: tb/tb_irq_controller.sv
// tb_irq_controller: directed checks of irq_controller priority, NMI, eret and reset behaviour
module tb_irq_controller;
`ifdef IRQ_NESTING_EN
  localparam bit NEST = 1'b1;
`else
  localparam bit NEST = 1'b0;
`endif
  logic        Clk = 1'b0, Reset = 1'b1, nmi_in = 1'b0, mask_we = 1'b0, isInterrupted = 1'b0, INA = 1'b0, eret = 1'b0;
  logic [3:0]  irq = '0, mask_wdata = '0, in_service;
  logic        INT, NMI, INTD, spurious, nmi_active;
  logic [2:0]  irq_id;
  logic [31:0] vector;
  int checks = 0, errors = 0;

  irq_controller dut (
    .Clk(Clk), .Reset(Reset), .irq(irq), .nmi_in(nmi_in), .mask_we(mask_we), .mask_wdata(mask_wdata),
    .isInterrupted(isInterrupted), .INA(INA), .eret(eret), .INT(INT), .NMI(NMI), .INTD(INTD),
    .irq_id(irq_id), .vector(vector), .spurious(spurious), .in_service(in_service), .nmi_active(nmi_active)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic load_mask(input logic [3:0] m);
    mask_we = 1'b1; mask_wdata = m;
    tick();
    mask_we = 1'b0;
  endtask

  task automatic accept(input logic ina);
    isInterrupted = 1'b1; INA = ina;
    tick();
    isInterrupted = 1'b0; INA = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL reset_int got %b exp 0", INT); end
    checks++; if (NMI !== 1'b0) begin errors++; $display("FAIL reset_nmi got %b exp 0", NMI); end
    checks++; if (INTD !== 1'b0) begin errors++; $display("FAIL reset_intd got %b exp 0", INTD); end
    checks++; if (vector !== 32'h100) begin errors++; $display("FAIL reset_vector got %h exp 100", vector); end
    checks++; if (irq_id !== 3'd0) begin errors++; $display("FAIL reset_id got %0d exp 0", irq_id); end
    checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL reset_isv got %b exp 0000", in_service); end
    checks++; if ({spurious, nmi_active} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {spurious, nmi_active}); end
  endtask

  task automatic test_basic();
    load_mask(4'b1111);
    irq = 4'b0100;
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL basic_int got %b exp 1", INT); end
    accept(1'b1);
    checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL basic_id got %0d exp 2", irq_id); end
    checks++; if (vector !== 32'h120) begin errors++; $display("FAIL basic_vector got %h exp 120", vector); end
    checks++; if (in_service !== 4'b0100) begin errors++; $display("FAIL basic_isv got %b exp 0100", in_service); end
    checks++; if (INT !== 1'b0) begin errors++; $display("FAIL basic_int_drop got %b exp 0", INT); end
    checks++; if (INTD !== !NEST) begin errors++; $display("FAIL basic_intd got %b exp %b", INTD, !NEST); end
    irq = 4'b0000;
    do_eret();
    checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL basic_eret_isv got %b exp 0000", in_service); end
  endtask

  task automatic test_mask_priority();
    load_mask(4'b1110);
    irq = 4'b1010;
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL mask_int got %b exp 1", INT); end
    accept(1'b1);
    checks++; if (irq_id !== 3'd1) begin errors++; $display("FAIL mask_id got %0d exp 1", irq_id); end
    checks++; if (vector !== 32'h110) begin errors++; $display("FAIL mask_vector got %h exp 110", vector); end
    irq = 4'b0000;
    do_eret();
    checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL mask_eret_isv got %b exp 0000", in_service); end
    checks++; if (INTD !== 1'b0) begin errors++; $display("FAIL mask_eret_intd got %b exp 0", INTD); end
  endtask

  task automatic test_nmi();
    load_mask(4'b1111);
    irq = 4'b0100;
    tick();
    accept(1'b1);
    nmi_in = 1'b1;
    tick();
    nmi_in = 1'b0;
    checks++; if (NMI !== 1'b1) begin errors++; $display("FAIL nmi_pend got %b exp 1", NMI); end
    accept(1'b0);
    checks++; if (vector !== 32'h80) begin errors++; $display("FAIL nmi_vector got %h exp 80", vector); end
    checks++; if (nmi_active !== 1'b1) begin errors++; $display("FAIL nmi_active got %b exp 1", nmi_active); end
    checks++; if (NMI !== 1'b0) begin errors++; $display("FAIL nmi_clear got %b exp 0", NMI); end
    checks++; if (INTD !== 1'b1) begin errors++; $display("FAIL nmi_intd got %b exp 1", INTD); end
    do_eret();
    checks++; if ({nmi_active, in_service} !== 5'b0_0100) begin errors++; $display("FAIL nmi_eret1 got %b exp 00100", {nmi_active, in_service}); end
    irq = 4'b0000;
    do_eret();
    checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL nmi_eret2 got %b exp 0000", in_service); end
    nmi_in = 1'b1;
    tick();
    nmi_in = 1'b0;
    tick();
    nmi_in = 1'b1;
    accept(1'b0);
    checks++; if ({NMI, nmi_active} !== 2'b11) begin errors++; $display("FAIL nmi_edge_on_accept got %b exp 11", {NMI, nmi_active}); end
    nmi_in = 1'b0;
    accept(1'b0);
    checks++; if ({NMI, nmi_active} !== 2'b01) begin errors++; $display("FAIL nmi_second_accept got %b exp 01", {NMI, nmi_active}); end
    do_eret();
    checks++; if (nmi_active !== 1'b0) begin errors++; $display("FAIL nmi_final_eret got %b exp 0", nmi_active); end
  endtask

  task automatic test_spurious();
    irq = 4'b0001;
    tick();
    checks++; if (INT !== 1'b1) begin errors++; $display("FAIL spur_int got %b exp 1", INT); end
    irq = 4'b0000;
    accept(1'b1);
    checks++; if (spurious !== 1'b1) begin errors++; $display("FAIL spur_flag got %b exp 1", spurious); end
    checks++; if (vector !== 32'h1F0) begin errors++; $display("FAIL spur_vector got %h exp 1f0", vector); end
    checks++; if (in_service !== 4'b0) begin errors++; $display("FAIL spur_isv got %b exp 0000", in_service); end
    checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL spur_id got %0d exp 2", irq_id); end
  endtask

  task automatic test_nmi_reset();
    irq = 4'b0010;
    tick();
    accept(1'b1);
    irq = 4'b0000;
    nmi_in = 1'b1; Reset = 1'b1;
    tick(); tick();
    Reset = 1'b0;
    tick();
    checks++; if (NMI !== 1'b0) begin errors++; $display("FAIL nmi_held_reset got %b exp 0", NMI); end
    checks++; if ({in_service, spurious} !== 5'b0) begin errors++; $display("FAIL reset_mid_service got %b exp 00000", {in_service, spurious}); end
    nmi_in = 1'b0;
    tick();
    nmi_in = 1'b1;
    tick();
    checks++; if (NMI !== 1'b1) begin errors++; $display("FAIL nmi_after_reset got %b exp 1", NMI); end
    nmi_in = 1'b0;
    accept(1'b0);
    do_eret();
  endtask

  task automatic test_nesting();
    load_mask(4'b1111);
    irq = 4'b1000;
    tick();
    accept(1'b1);
    checks++; if (in_service !== 4'b1000) begin errors++; $display("FAIL nest_isv3 got %b exp 1000", in_service); end
    irq = 4'b1001;
    tick();
    checks++; if (INT !== NEST) begin errors++; $display("FAIL nest_int got %b exp %b", INT, NEST); end
    if (NEST) begin
      accept(1'b1);
      checks++; if (in_service !== 4'b1001) begin errors++; $display("FAIL nest_isv got %b exp 1001", in_service); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_mask_priority();
    test_nmi();
    test_spurious();
    test_nmi_reset();
    test_nesting();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
